// File: rtl/modulo_unit.sv
// rtl/modulo_unit.sv - restoring shift-subtract remainder engine, one quotient bit per clock
module modulo_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             div_zero_o,
    output logic             busy_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [WIDTH:0]   r;
    logic [WIDTH:0]   t;
    logic [WIDTH:0]   r_nx;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             unused_r_msb;

    // Partial remainder always stays below d, so its top bit only matters inside t.
    assign t            = {r[WIDTH-1:0], q[WIDTH-1]};
    assign r_nx         = (t >= {1'b0, d}) ? (t - {1'b0, d}) : t;
    assign last         = (cnt == CW'(WIDTH - 1));
    assign unused_r_msb = r[WIDTH];

    assign ready_o = (state == DONE);
    assign busy_o  = (state == CALC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nx = (b_i == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (!start_i) begin
                    state_nx = IDLE;
                end else if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = start_i ? HOLD : IDLE;
            end
            HOLD: begin
                if (!start_i) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q          <= '0;
            d          <= '0;
            r          <= '0;
            cnt        <= '0;
            rem_o      <= '0;
            div_zero_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        q   <= a_i;
                        d   <= b_i;
                        r   <= '0;
                        cnt <= '0;
                        if (b_i == '0) begin
                            rem_o      <= a_i;
                            div_zero_o <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    // A dropped request aborts without touching the published result.
                    if (start_i) begin
                        r   <= r_nx;
                        q   <= {q[WIDTH-2:0], 1'b0};
                        cnt <= cnt + CW'(1);
                        if (last) begin
                            rem_o      <= r_nx[WIDTH-1:0];
                            div_zero_o <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_modulo_unit.sv
// tb/tb_modulo_unit.sv - randomized and directed self-checking bench for modulo_unit
module tb_modulo_unit;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_i = 1'b0;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         ready_o;
    logic [W-1:0] rem_o;
    logic         div_zero_o;
    logic         busy_o;

    int total = 0;
    int bad   = 0;
    int rdy_cnt = 0;
    bit started = 0;

    modulo_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .ready_o    (ready_o),
        .rem_o      (rem_o),
        .div_zero_o (div_zero_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: timeline of one request expressed as a phase plus a cycles-left count.
    typedef enum int {M_IDLE, M_RUN, M_RDY, M_HOLD} mph_t;
    mph_t         ph = M_IDLE;
    int           left = 0;
    logic [W-1:0] pa = '0, pb = '0, m_rem = '0;
    logic         m_dz = 1'b0;

    always @(posedge clk) begin
        started <= 1'b1;
        if (rst) begin
            ph    <= M_IDLE;
            m_rem <= '0;
            m_dz  <= 1'b0;
        end else begin
            case (ph)
                M_IDLE: if (start_i) begin
                    if (b_i == 0) begin
                        m_rem <= a_i;
                        m_dz  <= 1'b1;
                        ph    <= M_RDY;
                    end else begin
                        pa   <= a_i;
                        pb   <= b_i;
                        left <= W;
                        ph   <= M_RUN;
                    end
                end
                M_RUN: begin
                    if (!start_i) begin
                        ph <= M_IDLE;
                    end else begin
                        left <= left - 1;
                        if (left == 1) begin
                            m_rem <= pa % pb;
                            m_dz  <= 1'b0;
                            ph    <= M_RDY;
                        end
                    end
                end
                M_RDY:  ph <= start_i ? M_HOLD : M_IDLE;
                M_HOLD: if (!start_i) ph <= M_IDLE;
                default: ph <= M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("ready_o", {31'd0, ready_o}, {31'd0, ph == M_RDY});
            check("busy_o", {31'd0, busy_o}, {31'd0, ph == M_RUN});
            check("rem_o", {16'd0, rem_o}, {16'd0, m_rem});
            check("div_zero_o", {31'd0, div_zero_o}, {31'd0, m_dz});
        end
        if (ready_o === 1'b1) rdy_cnt++;
    end

    // One full request: launch, wait for the pulse, hold start a few cycles, release.
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      output logic [W-1:0] r, output logic dz);
        int  c0;
        int  lat;
        bit  got;
        @(negedge clk); #1;
        c0 = rdy_cnt;
        a_i = a; b_i = b; start_i = 1'b1;
        got = 0; lat = 0; r = '0; dz = 1'b0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk); #1;
            if (ready_o === 1'b1) begin
                got = 1; lat = i; r = rem_o; dz = div_zero_o;
            end
        end
        check("ready_seen", {31'd0, got}, 32'd1);
        check("latency", lat, (b == 0) ? 32'd1 : W + 1);
        repeat (3) begin @(negedge clk); #1; end
        check("one_pulse", rdy_cnt - c0, 32'd1);
        start_i = 1'b0;
        @(negedge clk); #1;
    endtask

    logic [W-1:0] r;
    logic         dz;
    int           c0;

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", {31'd0, ready_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_rem", {16'd0, rem_o}, 32'd0);
        check("rst_dz", {31'd0, div_zero_o}, 32'd0);
        rst = 1'b0;

        op(16'd100, 16'd36, r, dz);
        check("100mod36", {16'd0, r}, 32'd28);
        check("100mod36_dz", {31'd0, dz}, 32'd0);
        op(16'd7, 16'd9, r, dz);        check("7mod9", {16'd0, r}, 32'd7);
        op(16'hFFFF, 16'd1, r, dz);     check("ffffmod1", {16'd0, r}, 32'd0);
        op(16'hFFFF, 16'hFFFF, r, dz);  check("ffffmodffff", {16'd0, r}, 32'd0);
        op(16'hFFFE, 16'hFFFF, r, dz);  check("fffemodffff", {16'd0, r}, 32'hFFFE);
        op(16'd42, 16'd0, r, dz);
        check("42mod0", {16'd0, r}, 32'd42);
        check("42mod0_dz", {31'd0, dz}, 32'd1);
        op(16'd10, 16'd3, r, dz);
        check("10mod3", {16'd0, r}, 32'd1);
        check("10mod3_dz", {31'd0, dz}, 32'd0);

        // Abort after E5 of a 100 mod 36 run.
        op(16'd100, 16'd36, r, dz);
        a_i = 16'd100; b_i = 16'd36; start_i = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        start_i = 1'b0;
        c0 = rdy_cnt;
        repeat (W + 4) begin @(negedge clk); #1; end
        check("abort_no_pulse", rdy_cnt - c0, 32'd0);
        check("abort_rem_kept", {16'd0, rem_o}, 32'd28);
        op(16'd48, 16'd18, r, dz);      check("48mod18", {16'd0, r}, 32'd12);

        // Reset at E8 of a run.
        a_i = 16'd1000; b_i = 16'd7; start_i = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk); #1;
        check("midrst_ready", {31'd0, ready_o}, 32'd0);
        check("midrst_busy", {31'd0, busy_o}, 32'd0);
        check("midrst_rem", {16'd0, rem_o}, 32'd0);
        rst = 1'b0; start_i = 1'b0;
        c0 = rdy_cnt;
        repeat (W + 4) begin @(negedge clk); #1; end
        check("midrst_no_pulse", rdy_cnt - c0, 32'd0);
        op(16'd1000, 16'd7, r, dz);     check("1000mod7", {16'd0, r}, 32'd6);

        // Euclid loop as the GCD controller drives it.
        op(16'd252, 16'd105, r, dz);    check("gcd_252_105", {16'd0, r}, 32'd42);
        op(16'd105, 16'd42, r, dz);     check("gcd_105_42", {16'd0, r}, 32'd21);
        op(16'd42, 16'd21, r, dz);      check("gcd_42_21", {16'd0, r}, 32'd0);

        // Random operands, aborts, and operand churn after launch.
        for (int k = 0; k < 150; k++) begin
            logic [W-1:0] ra, rb;
            bit           got;
            ra = W'($urandom);
            case ($urandom_range(0, 4))
                0: rb = '0;
                1: rb = W'($urandom_range(1, 3));
                2: rb = W'($urandom_range(1, 255));
                3: rb = ra;
                default: rb = W'($urandom);
            endcase
            @(negedge clk); #1;
            a_i = ra; b_i = rb; start_i = 1'b1;
            if ($urandom_range(0, 6) == 0) begin
                repeat ($urandom_range(1, W)) begin
                    @(negedge clk); #1;
                    a_i = W'($urandom); b_i = W'($urandom);
                end
                start_i = 1'b0;
            end else begin
                got = 0;
                for (int i = 0; i < 40 && !got; i++) begin
                    @(negedge clk); #1;
                    if (ready_o === 1'b1) begin
                        got = 1;
                        check("rand_rem", {16'd0, rem_o}, (rb == 0) ? {16'd0, ra} : {16'd0, ra % rb});
                    end
                    a_i = W'($urandom); b_i = W'($urandom);
                end
                check("rand_ready_seen", {31'd0, got}, 32'd1);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                #1;
                start_i = 1'b0;
            end
            repeat ($urandom_range(1, 2)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/modulo_unit.md
# modulo_unit

Iterative remainder engine that computes `a_i mod b_i` for unsigned operands using restoring shift-subtract, one quotient bit per clock. It sits directly downstream of the GCD controller. It consumes the controller's level-held `modulo_start_o` and operands routed from the Zahl1/Zahl2 registers, and returns a one-cycle `ready_o` pulse with a stable remainder that the controller writes back in its `write_erg` step.

## Interface
- `WIDTH`, 16, operand and remainder width in bits (≥2)
- `clk` input 1: clock
- `rst` input 1: reset, synchronous, active-high
- `start_i` input 1: level request; held high by the requester for the whole operation
- `a_i` input WIDTH: dividend; sampled only on the launch edge
- `b_i` input WIDTH: divisor; sampled only on the launch edge
- `ready_o` output 1: one-cycle pulse; `rem_o` is valid while high
- `rem_o` output WIDTH: remainder; registered, held until the next completion
- `div_zero_o` output 1: set with `rem_o` when the divisor was 0
- `busy_o` output 1: high in CALC

## Operation
- States are IDLE, CALC, DONE and HOLD. Reset enters IDLE.
- Internal registers:
  - dividend shift register `q` (WIDTH)
  - divisor `d` (WIDTH)
  - partial remainder `r` (WIDTH+1 bits, so the compare never overflows)
  - iteration counter `cnt` (clog2(WIDTH+1) bits)
- IDLE, `start_i`=1:
  - latch `q`←`a_i` and `d`←`b_i`; clear `r` and `cnt`.
  - If `b_i`==0: go to DONE and load `rem_o`←`a_i`, `div_zero_o`←1.
  - Otherwise go to CALC.
- CALC, each edge:
  - form `t` = {`r`[WIDTH-1:0], `q`[WIDTH-1]}.
  - `r` ← (`t` ≥ `d`) ? `t`−`d` : `t`.
  - `q` ← `q`<<1; `cnt`++.
  - On the edge where `cnt`==WIDTH−1: load `rem_o` ← final `r`[WIDTH-1:0] and `div_zero_o`←0, then go to DONE.
- DONE: `ready_o`=1 for exactly one cycle. Next state is HOLD if `start_i`=1, otherwise IDLE.
- HOLD: wait until `start_i`=0, then go to IDLE. No relaunch is possible while `start_i` stays high. This covers the requester keeping start high in the cycle it samples ready.
- Abort: `start_i`=0 sampled in CALC returns the block to IDLE on that edge.
  - No `ready_o` pulse is produced.
  - `rem_o` and `div_zero_o` keep their previous values.
- Operand changes on `a_i`/`b_i` after the launch edge have no effect.
- Arithmetic is unsigned only. `a_i` < `b_i` still runs all WIDTH iterations and yields `a_i`. The result is always < `d` when `d`≠0.

## Timing
- Reset values: `ready_o`=0, `busy_o`=0, `rem_o`=0, `div_zero_o`=0, state IDLE, `r`/`q`/`d`/`cnt`=0.
- `rst` overrides everything on the same edge, including mid-CALC. No `ready_o` is produced afterwards.
- E0 is the edge that samples `start_i`=1 in IDLE.
- Normal path:
  - CALC iterations happen on edges E1..E_WIDTH.
  - `ready_o` is high in the cycle after E_WIDTH, with `rem_o` already valid.
  - Latency is WIDTH+1 cycles from E0 to the end of the ready cycle.
- Divide by zero: `ready_o` is high in the cycle after E0.
- `ready_o`, `busy_o` and `div_zero_o` are decoded from state or registers, with no combinational path from inputs.
- `rem_o` changes only on the edge entering DONE.
- Back-to-back operation: minimum launch spacing is one cycle after `start_i` has been sampled low.

## Test plan
- **Basic remainder:** WIDTH=16, `a`=100, `b`=36, `start_i` held high → `busy_o` for 16 cycles, then `ready_o` one cycle after E16 with `rem_o`=28 and `div_zero_o`=0. After that, HOLD with no second pulse until `start_i` falls.
- **Boundary operands:**
  - `a`=7, `b`=9 → `rem_o`=7
  - `a`=0xFFFF, `b`=1 → `rem_o`=0
  - `a`=0xFFFF, `b`=0xFFFF → `rem_o`=0
  - `a`=0xFFFE, `b`=0xFFFF → `rem_o`=0xFFFE
- **Divide by zero:** `a`=42, `b`=0 → `ready_o` in the cycle after E0, `rem_o`=42, `div_zero_o`=1. A following `a`=10, `b`=3 run → `rem_o`=1, `div_zero_o`=0.
- **Abort:** drop `start_i` after E5 of a 100 mod 36 run → IDLE, no `ready_o`, `rem_o` keeps its prior value. Relaunch with 48 mod 18 → `rem_o`=12.
- **Reset mid-operation:** assert `rst` at E8 → all outputs 0 next cycle, no `ready_o`. A following run completes normally.
- **Controller-style GCD loop:** run the Euclid sequence 252, 105 → 42, 21 → 0. Operands change only between operations, with `start_i` low for ≥1 cycle between runs. Each remainder is correct and each run produces exactly one `ready_o` pulse.
